// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: turns one scheduler entry into ACT0/ACT1/CAS0/CAS1/PRE
// on a single channel while enforcing tRCD, tRAS, tRTP, write recovery and tRP.
module ddr5_cmd_sequencer #(
    parameter int unsigned T_RCD = 39,
    parameter int unsigned T_RAS = 76,
    parameter int unsigned T_RTP = 18,
    parameter int unsigned T_CWL = 38,
    parameter int unsigned T_BL  = 8,
    parameter int unsigned T_WR  = 72,
    parameter int unsigned T_RP  = 39,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_opn,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        req_done,
    output logic        err_opn,
    output logic        busy
);

    localparam int unsigned RCD_E  = (T_RCD < 2) ? 2 : T_RCD;
    localparam int unsigned RP_E   = (T_RP < 1) ? 1 : T_RP;
    localparam int unsigned WR_SUM = T_CWL + T_BL + T_WR;

    // Counters are loaded one cycle "early" so a zero test steers the transition into the next state.
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(RCD_E - 1);
    localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'((T_RAS > 0) ? T_RAS - 1 : 0);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'((T_RTP > 0) ? T_RTP - 1 : 0);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'((WR_SUM > 0) ? WR_SUM - 1 : 0);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(RP_E - 1);

    localparam logic [2:0] C_ACT0  = 3'd0;
    localparam logic [2:0] C_ACT1  = 3'd1;
    localparam logic [2:0] C_RD0   = 3'd2;
    localparam logic [2:0] C_RD1   = 3'd3;
    localparam logic [2:0] C_WR0   = 3'd4;
    localparam logic [2:0] C_WR1   = 3'd5;
    localparam logic [2:0] C_PRE   = 3'd6;
    localparam logic [2:0] C_STALL = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           ent, ent_nxt;
    logic [CNT_W-1:0] ras_cnt, phase_cnt;
    logic             accept_c, take_c, pre_ok_c;

    logic             cmd_valid_d, req_ready_d, req_done_d, err_opn_d, busy_d;
    logic [2:0]       cmd_d;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    assign accept_c = req_valid && req_ready;
    assign take_c   = accept_c && (req_opn != 2'd3);
    assign pre_ok_c = (ras_cnt == '0) && (phase_cnt == '0);
    assign ent_nxt  = take_c ? entry_t'{wr: (req_opn == 2'd1), bg: req_bg, ba: req_ba,
                                        row: req_row, col: req_col} : ent;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (take_c) state_nxt = S_ACT0;
            S_ACT0:     state_nxt = S_ACT1;
            S_ACT1:     state_nxt = (phase_cnt == '0) ? S_CAS0 : S_WAIT_RCD;
            S_WAIT_RCD: if (phase_cnt == '0) state_nxt = S_CAS0;
            S_CAS0:     state_nxt = S_CAS1;
            S_CAS1:     state_nxt = pre_ok_c ? S_PRE : S_WAIT_PRE;
            S_WAIT_PRE: if (pre_ok_c) state_nxt = S_PRE;
            S_PRE:      state_nxt = (phase_cnt == '0) ? S_IDLE : S_WAIT_RP;
            S_WAIT_RP:  if (phase_cnt == '0) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        cmd_d       = C_STALL;
        cmd_valid_d = 1'b0;
        req_done_d  = 1'b0;
        req_ready_d = (state_nxt == S_IDLE);
        busy_d      = (state_nxt != S_IDLE);
        err_opn_d   = accept_c && (req_opn == 2'd3);
        case (state_nxt)
            S_ACT0: begin cmd_d = C_ACT0; cmd_valid_d = 1'b1; end
            S_ACT1: begin cmd_d = C_ACT1; cmd_valid_d = 1'b1; end
            S_CAS0: begin cmd_d = ent_nxt.wr ? C_WR0 : C_RD0; cmd_valid_d = 1'b1; end
            S_CAS1: begin cmd_d = ent_nxt.wr ? C_WR1 : C_RD1; cmd_valid_d = 1'b1; end
            S_PRE:  begin cmd_d = C_PRE; cmd_valid_d = 1'b1; req_done_d = 1'b1; end
            default: ;
        endcase
    end

    // Timing counters and latched entry; phase_cnt is reused for tRCD, CAS-to-PRE and tRP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_cnt   <= '0;
            phase_cnt <= '0;
            ent       <= '0;
        end else begin
            ent     <= ent_nxt;
            ras_cnt <= (state_nxt == S_ACT0) ? RAS_LOAD : sat_dec(ras_cnt);
            if (state_nxt == S_ACT0)      phase_cnt <= RCD_LOAD;
            else if (state_nxt == S_CAS0) phase_cnt <= ent_nxt.wr ? WR_LOAD : RD_LOAD;
            else if (state_nxt == S_PRE)  phase_cnt <= RP_LOAD;
            else                          phase_cnt <= sat_dec(phase_cnt);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= C_STALL;
            cmd_bg    <= '0;
            cmd_ba    <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            req_done  <= 1'b0;
            err_opn   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            cmd_valid <= cmd_valid_d;
            cmd       <= cmd_d;
            cmd_bg    <= ent_nxt.bg;
            cmd_ba    <= ent_nxt.ba;
            cmd_row   <= ent_nxt.row;
            cmd_col   <= ent_nxt.col;
            req_done  <= req_done_d;
            err_opn   <= err_opn_d;
            busy      <= busy_d;
            req_ready <= req_ready_d;
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer; "@k" means the value present just before clock edge k,
// where edge 0 is the edge that accepts the entry.
module tb_ddr5_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_valid2;
    logic [1:0]  req_opn;
    logic [2:0]  req_bg;
    logic [1:0]  req_ba;
    logic [15:0] req_row;
    logic [9:0]  req_col;

    logic        rdy_a, cv_a, done_a, err_a, busy_a;
    logic [2:0]  cmd_a, bg_a;
    logic [1:0]  ba_a;
    logic [15:0] row_a;
    logic [9:0]  col_a;
    logic        rdy_b, cv_b, done_b, err_b, busy_b;
    logic [2:0]  cmd_b, bg_b;
    logic [1:0]  ba_b;
    logic [15:0] row_b;
    logic [9:0]  col_b;

    int edge_n = 0;
    int base   = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    ddr5_cmd_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_opn(req_opn), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cv_a), .cmd(cmd_a), .cmd_bg(bg_a), .cmd_ba(ba_a), .cmd_row(row_a),
        .cmd_col(col_a), .req_done(done_a), .err_opn(err_a), .busy(busy_a)
    );

    ddr5_cmd_sequencer #(.T_RAS(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(rdy_b),
        .req_opn(req_opn), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cv_b), .cmd(cmd_b), .cmd_bg(bg_b), .cmd_ba(ba_b), .cmd_row(row_b),
        .cmd_col(col_b), .req_done(done_b), .err_opn(err_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic at(input int k);
        while (edge_n < base + k - 1) @(negedge clk);
    endtask

    task automatic set_entry(input logic [1:0] opn, input logic [2:0] bg, input logic [1:0] ba,
                             input logic [15:0] row, input logic [9:0] col);
        req_opn = opn; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    endtask

    // Checks every output for @1..@kmax of one sequence with hand-derived A/C/P/R cycles
    task automatic run_seq(input bit sel, input bit wr, input int a, input int c, input int p,
                           input int r, input int kmax, input logic [2:0] bg, input logic [1:0] ba,
                           input logic [15:0] row, input logic [9:0] col);
        logic [2:0] o_cmd, o_bg, e_cmd;
        logic [1:0] o_ba;
        logic [15:0] o_row;
        logic [9:0] o_col;
        logic o_cv, o_done, o_rdy, o_busy, o_err;
        for (int k = 1; k <= kmax; k++) begin
            at(k);
            o_cmd = sel ? cmd_b : cmd_a;   o_cv  = sel ? cv_b : cv_a;
            o_done = sel ? done_b : done_a; o_rdy = sel ? rdy_b : rdy_a;
            o_busy = sel ? busy_b : busy_a; o_err = sel ? err_b : err_a;
            o_bg = sel ? bg_b : bg_a; o_ba = sel ? ba_b : ba_a;
            o_row = sel ? row_b : row_a; o_col = sel ? col_b : col_a;
            e_cmd = 3'd7;
            if (k == a)          e_cmd = 3'd0;
            else if (k == a + 1) e_cmd = 3'd1;
            else if (k == c)     e_cmd = wr ? 3'd4 : 3'd2;
            else if (k == c + 1) e_cmd = wr ? 3'd5 : 3'd3;
            else if (k == p)     e_cmd = 3'd6;
            chk("cmd", k, 32'(o_cmd), 32'(e_cmd));
            chk("cmd_valid", k, 32'(o_cv), 32'(e_cmd != 3'd7));
            chk("req_done", k, 32'(o_done), 32'(k == p));
            chk("req_ready", k, 32'(o_rdy), 32'(k == r));
            chk("busy", k, 32'(o_busy), 32'(k != r));
            chk("err_opn", k, 32'(o_err), 32'd0);
            if (k == a || k == a + 1) begin
                chk("cmd_row", k, 32'(o_row), 32'(row));
                chk("cmd_bg", k, 32'(o_bg), 32'(bg));
                chk("cmd_ba", k, 32'(o_ba), 32'(ba));
            end
            if (k == c || k == c + 1) chk("cmd_col", k, 32'(o_col), 32'(col));
        end
    endtask

    task automatic launch(input bit sel);
        if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
        base = edge_n + 1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
        set_entry(2'd0, 3'd0, 2'd0, 16'h0, 10'h0);
        repeat (3) @(negedge clk);
        chk("rst_cmd", 0, 32'(cmd_a), 32'd7);
        chk("rst_cmd_valid", 0, 32'(cv_a), 32'd0);
        chk("rst_req_ready", 0, 32'(rdy_a), 32'd1);
        chk("rst_busy", 0, 32'(busy_a), 32'd0);
        chk("rst_row", 0, 32'(row_a), 32'd0);
        chk("rst_err", 0, 32'(err_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic read: PRE set by tRAS
        set_entry(2'd0, 3'd2, 2'd1, 16'h1234, 10'h03F);
        launch(1'b0); req_valid = 1'b0;
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 116, 3'd2, 2'd1, 16'h1234, 10'h03F);

        // Write: PRE set by write recovery
        set_entry(2'd1, 3'd5, 2'd3, 16'hABCD, 10'h2A5);
        launch(1'b0); req_valid = 1'b0;
        run_seq(1'b0, 1'b1, 1, 40, 158, 197, 197, 3'd5, 2'd3, 16'hABCD, 10'h2A5);

        // Short tRAS instance, instruction-fetch read: PRE set by tRTP
        set_entry(2'd2, 3'd7, 2'd2, 16'h0F0F, 10'h111);
        launch(1'b1); req_valid2 = 1'b0;
        run_seq(1'b1, 1'b0, 1, 40, 58, 97, 97, 3'd7, 2'd2, 16'h0F0F, 10'h111);

        // Back-to-back entries with req_valid held high
        set_entry(2'd0, 3'd1, 2'd0, 16'h1111, 10'h001);
        launch(1'b0);
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 116, 3'd1, 2'd0, 16'h1111, 10'h001);
        set_entry(2'd2, 3'd3, 2'd1, 16'h2222, 10'h002);
        base += 116;
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 116, 3'd3, 2'd1, 16'h2222, 10'h002);
        set_entry(2'd0, 3'd4, 2'd2, 16'h3333, 10'h003);
        base += 116;
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 116, 3'd4, 2'd2, 16'h3333, 10'h003);
        req_valid = 1'b0;

        // Illegal opn followed immediately by a read
        set_entry(2'd3, 3'd6, 2'd3, 16'hDEAD, 10'h3FF);
        launch(1'b0);
        chk("illegal_err_opn", 1, 32'(err_a), 32'd1);
        chk("illegal_cmd_valid", 1, 32'(cv_a), 32'd0);
        chk("illegal_req_ready", 1, 32'(rdy_a), 32'd1);
        chk("illegal_busy", 1, 32'(busy_a), 32'd0);
        set_entry(2'd0, 3'd2, 2'd2, 16'h4444, 10'h044);
        base += 1;
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 116, 3'd2, 2'd2, 16'h4444, 10'h044);
        req_valid = 1'b0;

        // Reset mid-sequence
        set_entry(2'd0, 3'd2, 2'd1, 16'h1234, 10'h03F);
        launch(1'b0); req_valid = 1'b0;
        run_seq(1'b0, 1'b0, 1, 40, 77, 116, 45, 3'd2, 2'd1, 16'h1234, 10'h03F);
        rst_n = 1'b0;
        #1;
        chk("abort_cmd_valid", 45, 32'(cv_a), 32'd0);
        chk("abort_cmd", 45, 32'(cmd_a), 32'd7);
        chk("abort_busy", 45, 32'(busy_a), 32'd0);
        chk("abort_req_ready", 45, 32'(rdy_a), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_cmd", i, 32'(cv_a), 32'd0);
            chk("abort_no_done", i, 32'(done_a), 32'd0);
        end
        set_entry(2'd1, 3'd0, 2'd0, 16'h5A5A, 10'h155);
        launch(1'b0); req_valid = 1'b0;
        run_seq(1'b0, 1'b1, 1, 40, 158, 197, 197, 3'd0, 2'd0, 16'h5A5A, 10'h155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
